pong_match_ctrl: RTL
====================

# pong_match_ctrl

Parametrised match controller for the pong design. It sits between `game_logic` and `game_display` and tracks the frame-level match flow. It detects goals from the ball X position once per frame, keeps both scores, and sequences the serve countdown, play, point hold and match-over states. `game_logic` uses its outputs to freeze or recentre the ball; the display and LEDs use them to show scores and the winner.

## Interface
Parameters:
- `X_POS_W`, 10, ball X coordinate width
- `SCORE_W`, 4, width of each score counter
- `WIN_SCORE`, 11, points needed to win; range 1 to 2**SCORE_W-1
- `GOAL_L_X`, 4, ball_x at or below this value is a goal against the left player
- `GOAL_R_X`, 635, ball_x at or above this value is a goal against the right player; must be greater than `GOAL_L_X`
- `SERVE_FRAMES`, 60, length of the serve countdown in frames; at least 1
- `POINT_FRAMES`, 30, length of the hold after a point in frames; at least 1

Ports:
- `clk_i`  in  1  system clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `new_frame_i`  in  1  one-cycle pulse per video frame
- `start_i`  in  1  start key, level; the block detects its rising edge internally
- `ball_x_i`  in  X_POS_W  current ball X, sampled only on `new_frame_i`
- `ball_run_o`  out  1  ball may move; high only in PLAY
- `ball_reset_o`  out  1  one-cycle pulse telling game_logic to recentre the ball
- `serve_dir_o`  out  1  serve direction: 0 = toward left, 1 = toward right
- `score_l_o`, `score_r_o`  out  SCORE_W  scores
- `state_o`  out  3  current state encoding, from the package
- `match_over_o`  out  1  high in OVER
- `winner_o`  out  1  0 = left won, 1 = right won; valid while `match_over_o` is high

## Operation
- States: IDLE, SERVE, PLAY, POINT, OVER.
- IDLE: waits for a `start_i` rising edge, then clears both scores, sets `serve_dir_o`=0, pulses `ball_reset_o` and enters SERVE.
- SERVE: on entry the frame counter loads `SERVE_FRAMES`-1. Each `new_frame_i` pulse decrements it. A `new_frame_i` pulse with the counter at 0 moves to PLAY.
- PLAY: goals are checked on each `new_frame_i` pulse.
  - `ball_x_i` ≤ `GOAL_L_X`: right scores, `serve_dir_o` becomes 0.
  - `ball_x_i` ≥ `GOAL_R_X`: left scores, `serve_dir_o` becomes 1.
  - The ball is always served toward the player who conceded.
  - After a goal the block enters POINT and the counter loads `POINT_FRAMES`-1.
- POINT: the counter counts frames exactly as in SERVE. When it expires:
  - if the win condition holds, go to OVER and latch `winner_o`;
  - otherwise pulse `ball_reset_o` and go to SERVE.
- Win condition: the scorer has reached at least `WIN_SCORE` points.
- Saturation: a score never wraps. If a point brings any score to 2**SCORE_W-1, the win condition holds regardless of lead.
- OVER: scores and winner hold. A `start_i` rising edge behaves as in IDLE.
- A `start_i` edge in SERVE, PLAY or POINT is ignored.
- `new_frame_i` is ignored in IDLE and OVER.

## Timing
- Reset values: state IDLE, `score_l_o`=`score_r_o`=0, `serve_dir_o`=0, `winner_o`=0. `ball_run_o`, `ball_reset_o` and `match_over_o` are all 0. The counter is 0 and the edge-detector history is 0.
- Reset asserted mid-match aborts immediately and all outputs return to their reset values asynchronously.
- All outputs are registered, with no combinational path from input to output.
- A `start_i` rising edge registered at cycle n puts the block in SERVE with `ball_reset_o`=1 at cycle n+1. The key is synchronised externally.
- A goal frame pulse at cycle n gives the updated score, POINT state and `ball_run_o`=0 at n+1.
- The PLAY→POINT transition and the score update happen in the same cycle.
- `ball_reset_o` is high for exactly one cycle per entry to SERVE.
- A goal and the timer expiry cannot coincide, since they belong to different states.

## Configuration
- Macro: `PONG_WIN_BY_TWO_EN`.
- Defined: the win condition additionally requires the scorer's lead to be at least 2. Saturation still forces the win.
- Undefined: the first player to reach `WIN_SCORE` wins.

## Structure
- Package `pong_match_pkg` holds:
  - the state enum, 3-bit encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4;
  - the serve direction constants `SERVE_LEFT`/`SERVE_RIGHT`.
- Sub-module `pong_frame_timer`: a loadable down-counter that decrements on `new_frame_i` and flags expiry when a frame arrives at 0. It is instantiated once and loaded with either `SERVE_FRAMES`-1 or `POINT_FRAMES`-1.

## Test plan
Parameters for all scenarios: `WIN_SCORE`=3, `SERVE_FRAMES`=2, `POINT_FRAMES`=1, `SCORE_W`=4.
- Start from reset: `start_i` rises → next cycle state=SERVE and `ball_reset_o` pulses once. After 2 frames state=PLAY and `ball_run_o`=1.
- Left goal: in PLAY, frame with `ball_x_i`=2 → `score_r_o`=1, `serve_dir_o`=0, state=POINT. After 1 frame, `ball_reset_o` pulses and state=SERVE.
- Right goal at the boundary: frame with `ball_x_i`=635 → `score_l_o`+1, `serve_dir_o`=1. A frame with `ball_x_i`=634 produces no goal.
- Match end without the macro: left reaches 3 points → after the POINT frame, state=OVER, `match_over_o`=1, `winner_o`=0. A further `start_i` edge clears the scores and enters SERVE.
- Match end with `PONG_WIN_BY_TWO_EN`: score 3–3, then left scores → 4–3, no win, back to SERVE. Left scores again → 5–3 and OVER.
- Reset mid-PLAY at score 2–1: drive `rst_ni` low → all outputs return to their reset values in the same cycle. `start_i` edges in PLAY are ignored.

Source files
------------

// File: rtl/pong_match_pkg.sv
// pong_match_pkg
// Shared definitions for the pong match controller:
//   - match_state_e : 3-bit match state encoding (IDLE=0 .. OVER=4)
//   - SERVE_LEFT / SERVE_RIGHT : serve direction values driven on serve_dir_o
package pong_match_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } match_state_e;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer
// Loadable frame down-counter. It decrements once per frame pulse and flags
// expiry when a frame pulse arrives while the count is already zero. A load
// takes priority over counting.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   load_i         load load_val_i into the counter this cycle
//   load_val_i     value to load (frames - 1)
//   frame_i        frame pulse (already qualified by the caller)
//   expire_o       frame pulse seen with the counter at zero (combinational)
module pong_frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             frame_i,
  output logic             expire_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (frame_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_ONE;
    end
  end

  assign expire_o = frame_i && (cnt_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
// Frame-level match controller for pong: detects goals from the ball X
// position on each frame pulse, keeps both scores, and sequences
// IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER).
// Optional build macro: PONG_WIN_BY_TWO_EN (win also needs a lead of 2;
// a saturated score still forces the win).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   new_frame_i     one-cycle pulse per video frame
//   start_i         start key level (rising edge detected here)
//   ball_x_i        ball X, sampled only on new_frame_i
//   ball_run_o      ball may move (PLAY only)
//   ball_reset_o    one-cycle recentre pulse on each SERVE entry
//   serve_dir_o     0 = serve toward left, 1 = toward right
//   score_l_o/r_o   player scores (saturating)
//   state_o         current state encoding (match_state_e)
//   match_over_o    high in OVER
//   winner_o        0 = left won, 1 = right won (valid with match_over_o)
module pong_match_ctrl
  import pong_match_pkg::*;
#(
  parameter int X_POS_W      = 10,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 11,
  parameter int GOAL_L_X     = 4,
  parameter int GOAL_R_X     = 635,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               new_frame_i,
  input  logic               start_i,
  input  logic [X_POS_W-1:0] ball_x_i,
  output logic               ball_run_o,
  output logic               ball_reset_o,
  output logic               serve_dir_o,
  output logic [SCORE_W-1:0] score_l_o,
  output logic [SCORE_W-1:0] score_r_o,
  output logic [2:0]         state_o,
  output logic               match_over_o,
  output logic               winner_o
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 2) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [X_POS_W-1:0] GOAL_L     = X_POS_W'(GOAL_L_X);
  localparam logic [X_POS_W-1:0] GOAL_R     = X_POS_W'(GOAL_R_X);

`ifdef PONG_WIN_BY_TWO_EN
  localparam bit WIN_BY_TWO = 1'b1;
`else
  localparam bit WIN_BY_TWO = 1'b0;
`endif

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

  // Saturation forces the win even without the required lead.
  function automatic logic win_check(input logic [SCORE_W-1:0] scorer,
                                     input logic [SCORE_W-1:0] other);
    logic reached;
    logic lead_ok;
    reached = (scorer >= WIN_S);
    lead_ok = ({1'b0, scorer} >= ({1'b0, other} + (SCORE_W + 1)'(2)));
    return (reached && (lead_ok || !WIN_BY_TWO)) || (scorer == SCORE_MAX);
  endfunction

  match_state_e       state_q, state_d;
  logic               start_q;
  logic               start_rise;
  logic               goal_l, goal_r;
  logic               tmr_frame, tmr_load, tmr_expire;
  logic [CNT_W-1:0]   tmr_val;
  logic [SCORE_W-1:0] score_l_q, score_r_q;
  logic [SCORE_W-1:0] scorer, other;
  logic               serve_dir_q, winner_q;
  logic               win_now;
  logic               ball_run_q, ball_reset_q, match_over_q;
  logic               ball_run_d, ball_reset_d, match_over_d;

  assign start_rise = start_i && !start_q;
  assign goal_l     = new_frame_i && (ball_x_i <= GOAL_L);
  assign goal_r     = new_frame_i && (ball_x_i >= GOAL_R);
  assign tmr_frame  = new_frame_i && ((state_q == ST_SERVE) || (state_q == ST_POINT));

  // The last goal decides the serve direction, so it also identifies the scorer.
  assign scorer  = (serve_dir_q == SERVE_LEFT) ? score_r_q : score_l_q;
  assign other   = (serve_dir_q == SERVE_LEFT) ? score_l_q : score_r_q;
  assign win_now = win_check(scorer, other);

  pong_frame_timer #(
    .CNT_W(CNT_W)
  ) u_frame_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .frame_i   (tmr_frame),
    .expire_o  (tmr_expire)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: if (start_rise) state_d = ST_SERVE;
      ST_SERVE:         if (tmr_expire) state_d = ST_PLAY;
      ST_PLAY:          if (goal_l || goal_r) state_d = ST_POINT;
      ST_POINT:         if (tmr_expire) state_d = win_now ? ST_OVER : ST_SERVE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Output logic (next values of the registered outputs, timer loads)
  always_comb begin
    ball_run_d   = (state_d == ST_PLAY);
    ball_reset_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    match_over_d = (state_d == ST_OVER);
    tmr_load     = ball_reset_d || ((state_d == ST_POINT) && (state_q != ST_POINT));
    tmr_val      = ball_reset_d ? SERVE_LOAD : POINT_LOAD;
  end

  // Registered outputs and match datapath
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q      <= 1'b0;
      ball_run_q   <= 1'b0;
      ball_reset_q <= 1'b0;
      match_over_q <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      serve_dir_q  <= SERVE_LEFT;
      winner_q     <= 1'b0;
    end else begin
      start_q      <= start_i;
      ball_run_q   <= ball_run_d;
      ball_reset_q <= ball_reset_d;
      match_over_q <= match_over_d;
      if (((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_rise) begin
        score_l_q   <= '0;
        score_r_q   <= '0;
        serve_dir_q <= SERVE_LEFT;
        winner_q    <= 1'b0;
      end else if (state_q == ST_PLAY) begin
        if (goal_l) begin
          score_r_q   <= sat_inc(score_r_q);
          serve_dir_q <= SERVE_LEFT;
        end else if (goal_r) begin
          score_l_q   <= sat_inc(score_l_q);
          serve_dir_q <= SERVE_RIGHT;
        end
      end else if ((state_q == ST_POINT) && tmr_expire && win_now) begin
        winner_q <= (serve_dir_q == SERVE_LEFT);
      end
    end
  end

  assign ball_run_o   = ball_run_q;
  assign ball_reset_o = ball_reset_q;
  assign serve_dir_o  = serve_dir_q;
  assign score_l_o    = score_l_q;
  assign score_r_o    = score_r_q;
  assign state_o      = state_q;
  assign match_over_o = match_over_q;
  assign winner_o     = winner_q;

endmodule
